// File: rtl/perf_sample_ctrl_pkg.sv
// Shared types and constants for the perf counter sampler: beat record, FSM states and
// the default sweep window over the machine counter CSR offsets.
package perf_sample_ctrl_pkg;

    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MHPMCOUNTER13  = 12'hB0D;
    localparam logic [4:0]  CTR_FIRST_DEF      = CSR_MCYCLE[4:0];
    localparam logic [4:0]  CTR_LAST_DEF       = CSR_MHPMCOUNTER13[4:0];

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_WAIT,
        PS_SCAN,
        PS_DRAIN
    } ps_state_e;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic [15:0] seq;
        logic        last;
    } perf_sample_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/perf_sample_ctrl_if.sv
// Sample stream from the sweep engine to the trace/log sink.
interface perf_sample_ctrl_if;
    logic        smp_valid;
    logic        smp_ready;
    logic [4:0]  smp_idx;
    logic [63:0] smp_data;
    logic [15:0] smp_seq;
    logic        smp_last;

    // A beat transfers on a clock edge where smp_valid && smp_ready; while valid is high and
    // ready low the master keeps valid asserted and idx/data/seq/last unchanged.
    modport master (output smp_valid, smp_idx, smp_data, smp_seq, smp_last, input smp_ready);
    modport slave  (input smp_valid, smp_idx, smp_data, smp_seq, smp_last, output smp_ready);
endinterface

// File: rtl/perf_sample_ctrl_timer.sv
// Sample period timer: reloads on enable rise and after each tick; a period of 0 behaves as 1.
module perf_period_timer #(
    parameter int unsigned PERIOD_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d, reload;
    logic                en_q;

    assign reload = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    assign tick_o = en_i && en_q && (cnt_q == '0);

    // Held at the reload value while disabled so the first sweep waits a full period.
    always_comb begin
        cnt_d = cnt_q - PERIOD_W'(1);
        if (!en_i || !en_q || (cnt_q == '0)) begin
            cnt_d = reload;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_i;
        end
    end

endmodule

// File: rtl/perf_sample_ctrl.sv
// Periodic sampler for the perf counter bank port: CSR accesses have priority, the sweep engine
// streams counters CTR_FIRST..CTR_LAST to the trace sink, optionally clearing each one it reads.
module perf_sample_ctrl
    import perf_sample_ctrl_pkg::*;
#(
    parameter logic [4:0]  CTR_FIRST = CTR_FIRST_DEF,
    parameter logic [4:0]  CTR_LAST  = CTR_LAST_DEF,
    parameter int unsigned PERIOD_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                csr_req_i,
    input  logic [4:0]          csr_addr_i,
    input  logic                csr_we_i,
    input  logic [63:0]         csr_wdata_i,
    output logic [63:0]         csr_rdata_o,
    input  logic                cfg_en_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic                cfg_clear_i,
    output logic [4:0]          pc_addr_o,
    output logic                pc_we_o,
    output logic [63:0]         pc_wdata_o,
    input  logic [63:0]         pc_rdata_i,
    perf_sample_ctrl_if.master  smp,
    output logic                busy_o,
    output logic [15:0]         dropped_o,
    output ps_state_e           state_o
);

    ps_state_e    state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [15:0]  seq_q, seq_d;
    logic [15:0]  dropped_q, dropped_d;
    perf_sample_t beat_q, beat_d;
    logic         valid_q, valid_d;
    logic         tick, issue, accept, last_acc, sweeping;

    perf_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (cfg_en_i),
        .period_i (cfg_period_i),
        .tick_o   (tick)
    );

    assign sweeping = (state_q == PS_SCAN) || (state_q == PS_DRAIN);
    assign accept   = valid_q && smp.smp_ready;
    assign last_acc = accept && beat_q.last;
    // A read is issued only when the output register is free or being emptied this cycle.
    assign issue    = (state_q == PS_SCAN) && !csr_req_i && (!valid_q || smp.smp_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PS_IDLE:  if (cfg_en_i) state_d = PS_WAIT;
            PS_WAIT: begin
                if (!cfg_en_i)  state_d = PS_IDLE;
                else if (tick)  state_d = PS_SCAN;
            end
            PS_SCAN:  if (issue && (idx_q == CTR_LAST)) state_d = PS_DRAIN;
            PS_DRAIN: if (last_acc) state_d = cfg_en_i ? PS_WAIT : PS_IDLE;
            default:  state_d = PS_IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        valid_d   = valid_q;
        beat_d    = beat_q;
        seq_d     = last_acc ? seq_q + 16'd1 : seq_q;
        dropped_d = (tick && sweeping) ? sat_inc16(dropped_q) : dropped_q;
        if (issue) begin
            idx_d       = (idx_q == CTR_LAST) ? CTR_FIRST : idx_q + 5'd1;
            valid_d     = 1'b1;
            beat_d.idx  = idx_q;
            beat_d.data = pc_rdata_i;
            beat_d.seq  = seq_q;
            beat_d.last = (idx_q == CTR_LAST);
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Read-clear is atomic with the sample read: the bank reads before it writes in one cycle.
    always_comb begin
        pc_addr_o  = '0;
        pc_we_o    = 1'b0;
        pc_wdata_o = '0;
        if (csr_req_i) begin
            pc_addr_o  = csr_addr_i;
            pc_we_o    = csr_we_i;
            pc_wdata_o = csr_wdata_i;
        end else if (issue) begin
            pc_addr_o = idx_q;
            pc_we_o   = cfg_clear_i;
        end
    end

    assign csr_rdata_o   = csr_req_i ? pc_rdata_i : '0;
    assign smp.smp_valid = valid_q;
    assign smp.smp_idx   = beat_q.idx;
    assign smp.smp_data  = beat_q.data;
    assign smp.smp_seq   = beat_q.seq;
    assign smp.smp_last  = beat_q.last;
    assign busy_o        = sweeping;
    assign dropped_o     = dropped_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PS_IDLE;
            idx_q     <= CTR_FIRST;
            seq_q     <= '0;
            dropped_q <= '0;
            beat_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            dropped_q <= dropped_d;
            beat_q    <= beat_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// Directed bench for perf_sample_ctrl with a behavioural counter bank (read-before-write).
module tb_perf_sample_ctrl;
    import perf_sample_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        csr_req_i = 1'b0;
    logic [4:0]  csr_addr_i = '0;
    logic        csr_we_i = 1'b0;
    logic [63:0] csr_wdata_i = '0;
    logic [63:0] csr_rdata_o;
    logic        cfg_en_i = 1'b0;
    logic [31:0] cfg_period_i = 32'd4;
    logic        cfg_clear_i = 1'b0;
    logic [4:0]  pc_addr_o;
    logic        pc_we_o;
    logic [63:0] pc_wdata_o;
    logic [63:0] pc_rdata_i;
    logic        busy_o;
    logic [15:0] dropped_o;
    ps_state_e   state_o;

    logic [63:0] bank [32];
    int checks = 0;
    int failures = 0;

    perf_sample_ctrl_if sif ();

    perf_sample_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .csr_req_i    (csr_req_i),
        .csr_addr_i   (csr_addr_i),
        .csr_we_i     (csr_we_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .cfg_en_i     (cfg_en_i),
        .cfg_period_i (cfg_period_i),
        .cfg_clear_i  (cfg_clear_i),
        .pc_addr_o    (pc_addr_o),
        .pc_we_o      (pc_we_o),
        .pc_wdata_o   (pc_wdata_o),
        .pc_rdata_i   (pc_rdata_i),
        .smp          (sif.master),
        .busy_o       (busy_o),
        .dropped_o    (dropped_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    assign pc_rdata_i = bank[pc_addr_o];
    always @(posedge clk_i) if (pc_we_o) bank[pc_addr_o] <= pc_wdata_o;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] init_val(input int i);
        return 64'h0123_4567_0000_0000 + 64'(i);
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        cfg_en_i = 1'b0; cfg_clear_i = 1'b0; cfg_period_i = 32'd4;
        csr_req_i = 1'b0; csr_addr_i = '0; csr_we_i = 1'b0; csr_wdata_i = '0;
        sif.smp_ready = 1'b1;
        for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cfg_en_i = 1'b1;
        sif.smp_ready = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (state_o !== PS_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_o, PS_IDLE); end
        checks++; if (sif.smp_valid !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL reset_valid_busy: got %b%b want 00", sif.smp_valid, busy_o); end
        checks++; if (dropped_o !== 16'd0 || sif.smp_seq !== 16'd0) begin failures++; $display("FAIL reset_counts: got %h/%h want 0/0", dropped_o, sif.smp_seq); end
        checks++; if (pc_addr_o !== 5'd0 || pc_we_o !== 1'b0 || csr_rdata_o !== 64'd0) begin failures++; $display("FAIL reset_port: got %h %b %h want 0", pc_addr_o, pc_we_o, csr_rdata_o); end
    endtask

    task automatic test_sweep();
        int n;
        int gaps;
        bit found;
        do_reset();
        cfg_period_i = 32'd4;
        cfg_en_i = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL sweep_start_early: got busy %b want 0", busy_o); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1 || pc_addr_o !== 5'd0) begin failures++; $display("FAIL sweep_start: got busy %b addr %0d want 1 0", busy_o, pc_addr_o); end
        n = 0; gaps = 0;
        for (int c = 0; c < 40 && n < 14; c++) begin
            @(negedge clk_i);
            if (sif.smp_valid) begin
                checks++;
                if (sif.smp_idx !== 5'(n) || sif.smp_data !== init_val(n) || sif.smp_last !== (n == 13) || sif.smp_seq !== 16'd0) begin
                    failures++;
                    $display("FAIL sweep_beat: got idx %0d data %h last %b seq %0d want idx %0d data %h last %b seq 0",
                             sif.smp_idx, sif.smp_data, sif.smp_last, sif.smp_seq, n, init_val(n), (n == 13));
                end
                n++;
            end else begin
                gaps++;
            end
        end
        checks++; if (n != 14 || gaps != 0) begin failures++; $display("FAIL sweep_count: got beats %0d gaps %0d want 14 0", n, gaps); end
        @(negedge clk_i);
        checks++; if (dropped_o !== 16'd3) begin failures++; $display("FAIL sweep_dropped: got %0d want 3", dropped_o); end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk_i);
            if (sif.smp_valid) found = 1'b1;
        end
        checks++; if (!found || sif.smp_idx !== 5'd0 || sif.smp_seq !== 16'd1) begin failures++; $display("FAIL sweep_second: got found %b idx %0d seq %0d want 1 0 1", found, sif.smp_idx, sif.smp_seq); end
        cfg_en_i = 1'b0;
        for (int c = 0; c < 40 && busy_o; c++) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || state_o !== PS_IDLE) begin failures++; $display("FAIL sweep_finish_idle: got busy %b state %0d want 0 %0d", busy_o, state_o, PS_IDLE); end
    endtask

    task automatic test_csr_priority();
        int n;
        int k;
        bit armed;
        do_reset();
        cfg_en_i = 1'b1;
        n = 0; k = 0; armed = 1'b1;
        for (int c = 0; c < 60 && n < 14; c++) begin
            @(negedge clk_i);
            if (csr_req_i) begin
                checks++;
                if (pc_addr_o !== 5'd20 || csr_rdata_o !== init_val(20) || pc_we_o !== 1'b0) begin
                    failures++;
                    $display("FAIL csr_mux: got addr %0d rdata %h we %b want 20 %h 0", pc_addr_o, csr_rdata_o, pc_we_o, init_val(20));
                end
                k++;
                if (k == 3) csr_req_i = 1'b0;
            end
            if (sif.smp_valid) begin
                checks++;
                if (sif.smp_idx !== 5'(n) || sif.smp_data !== init_val(n)) begin
                    failures++;
                    $display("FAIL csr_beat: got idx %0d data %h want idx %0d data %h", sif.smp_idx, sif.smp_data, n, init_val(n));
                end
                n++;
            end
            if (armed && !csr_req_i && busy_o && pc_addr_o == 5'd5) begin
                armed = 1'b0;
                csr_addr_i = 5'd20;
                csr_req_i = 1'b1;
            end
        end
        checks++; if (n != 14 || k != 3) begin failures++; $display("FAIL csr_count: got beats %0d csr cycles %0d want 14 3", n, k); end
        checks++; if (csr_rdata_o !== 64'd0) begin failures++; $display("FAIL csr_rdata_idle: got %h want 0", csr_rdata_o); end
    endtask

    task automatic test_stall();
        int n;
        int k;
        bit stalled;
        do_reset();
        cfg_en_i = 1'b1;
        n = 0; k = 0; stalled = 1'b0;
        for (int c = 0; c < 80 && n < 14; c++) begin
            @(negedge clk_i);
            if (!sif.smp_ready) begin
                checks++;
                if (sif.smp_valid !== 1'b1 || sif.smp_idx !== 5'd7 || sif.smp_data !== init_val(7) || pc_addr_o !== 5'd0 || pc_we_o !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold: got valid %b idx %0d data %h addr %0d want 1 7 %h 0", sif.smp_valid, sif.smp_idx, sif.smp_data, pc_addr_o, init_val(7));
                end
                k++;
                if (k == 10) sif.smp_ready = 1'b1;
            end
            if (!stalled && sif.smp_valid && sif.smp_idx == 5'd7) begin
                stalled = 1'b1;
                sif.smp_ready = 1'b0;
            end
            if (sif.smp_valid && sif.smp_ready) begin
                checks++;
                if (sif.smp_idx !== 5'(n) || sif.smp_data !== init_val(n) || sif.smp_seq !== 16'd0) begin
                    failures++;
                    $display("FAIL stall_beat: got idx %0d data %h seq %0d want idx %0d data %h seq 0", sif.smp_idx, sif.smp_data, sif.smp_seq, n, init_val(n));
                end
                n++;
            end
        end
        checks++; if (n != 14 || k != 10) begin failures++; $display("FAIL stall_count: got beats %0d stall %0d want 14 10", n, k); end
    endtask

    task automatic test_clear();
        int n;
        int we_n;
        bit got2;
        do_reset();
        for (int i = 0; i < 32; i++) bank[i] <= 64'd100;
        cfg_clear_i = 1'b1;
        cfg_en_i = 1'b1;
        n = 0; we_n = 0; got2 = 1'b0;
        for (int c = 0; c < 80 && !got2; c++) begin
            @(negedge clk_i);
            if (pc_we_o) begin
                checks++;
                if (pc_wdata_o !== 64'd0 || pc_addr_o !== 5'(we_n % 14)) begin
                    failures++;
                    $display("FAIL clear_write: got addr %0d wdata %h want %0d 0", pc_addr_o, pc_wdata_o, we_n % 14);
                end
                we_n++;
            end
            if (sif.smp_valid) begin
                checks++;
                if (sif.smp_seq == 16'd0) begin
                    if (sif.smp_idx !== 5'(n) || sif.smp_data !== 64'd100) begin
                        failures++;
                        $display("FAIL clear_beat: got idx %0d data %0d want idx %0d data 100", sif.smp_idx, sif.smp_data, n);
                    end
                    n++;
                end else begin
                    if (sif.smp_idx !== 5'd0 || sif.smp_data !== 64'd0 || sif.smp_seq !== 16'd1) begin
                        failures++;
                        $display("FAIL clear_next_sweep: got idx %0d data %0d seq %0d want 0 0 1", sif.smp_idx, sif.smp_data, sif.smp_seq);
                    end
                    got2 = 1'b1;
                end
            end
        end
        checks++; if (n != 14 || !got2 || we_n < 14) begin failures++; $display("FAIL clear_count: got beats %0d next %b writes %0d want 14 1 >=14", n, got2, we_n); end
        checks++; if (bank[13] !== 64'd0 || bank[14] !== 64'd100) begin failures++; $display("FAIL clear_bank: got %0d %0d want 0 100", bank[13], bank[14]); end
    endtask

    task automatic test_dropped();
        bit saw_fffe;
        do_reset();
        cfg_period_i = 32'd2;
        sif.smp_ready = 1'b0;
        cfg_en_i = 1'b1;
        for (int c = 0; c < 10 && !busy_o; c++) @(negedge clk_i);
        repeat (40) @(negedge clk_i);
        checks++; if (dropped_o !== 16'd20 || sif.smp_valid !== 1'b1 || sif.smp_idx !== 5'd0) begin failures++; $display("FAIL dropped_count: got %0d valid %b idx %0d want 20 1 0", dropped_o, sif.smp_valid, sif.smp_idx); end
        cfg_period_i = 32'd0;
        repeat (3) @(negedge clk_i);
        checks++; if (dropped_o !== 16'd22) begin failures++; $display("FAIL dropped_period0: got %0d want 22", dropped_o); end
        saw_fffe = 1'b0;
        for (int c = 0; c < 70000 && dropped_o !== 16'hFFFF; c++) begin
            @(negedge clk_i);
            if (dropped_o == 16'hFFFE) saw_fffe = 1'b1;
        end
        checks++; if (dropped_o !== 16'hFFFF || !saw_fffe) begin failures++; $display("FAIL dropped_reach_max: got %h saw_fffe %b want ffff 1", dropped_o, saw_fffe); end
        repeat (5) @(negedge clk_i);
        checks++; if (dropped_o !== 16'hFFFF) begin failures++; $display("FAIL dropped_saturate: got %h want ffff", dropped_o); end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        cfg_en_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk_i);
            if (sif.smp_valid && sif.smp_seq == 16'd1 && sif.smp_idx == 5'd3) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL arst_setup: got found 0 want 1"); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (sif.smp_valid !== 1'b0 || sif.smp_idx !== 5'd0 || sif.smp_data !== 64'd0 || sif.smp_seq !== 16'd0 || sif.smp_last !== 1'b0) begin
            failures++;
            $display("FAIL arst_stream: got valid %b idx %0d data %h seq %0d last %b want all 0", sif.smp_valid, sif.smp_idx, sif.smp_data, sif.smp_seq, sif.smp_last);
        end
        checks++; if (busy_o !== 1'b0 || dropped_o !== 16'd0 || pc_addr_o !== 5'd0 || pc_we_o !== 1'b0 || state_o !== PS_IDLE) begin
            failures++;
            $display("FAIL arst_ctrl: got busy %b dropped %0d addr %0d we %b state %0d want 0 0 0 0 0", busy_o, dropped_o, pc_addr_o, pc_we_o, state_o);
        end
        @(negedge clk_i);
        cfg_en_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (state_o !== PS_IDLE || sif.smp_seq !== 16'd0 || sif.smp_valid !== 1'b0) begin failures++; $display("FAIL arst_release: got state %0d seq %0d valid %b want 0 0 0", state_o, sif.smp_seq, sif.smp_valid); end
    endtask

    initial begin
        sif.smp_ready = 1'b1;
        for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
        test_reset();
        test_sweep();
        test_csr_priority();
        test_stall();
        test_clear();
        test_dropped();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
